// File: rtl/sev_seg_arb.sv
// Round-robin arbiter and 4-digit seven-segment multiplexer: PC view when idle, requester words when granted.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module sev_seg_arb #(
    parameter int unsigned CLK_DIV     = 100_000,
    parameter int unsigned HOLD_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pc_addr,
    input  logic [1:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    output logic [1:0]  gnt,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned FW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SHOW0, SHOW1} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic [1:0]    digit_sel;
    logic [FW-1:0] frame_cnt, frame_cnt_d, frame_inc;
    logic          rr, rr_d;
    logic [15:0]   word, word_d, dword;
    logic [1:0]    gnt_d;
    logic [3:0]    nib, an_d;
    logic [6:0]    seg_d;
    logic          tick, frame_end, own, lit, grant_en, grant_sel;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick      = (cnt == CW'(CLK_DIV - 1));
    assign frame_end = tick && (digit_sel == 2'd3);

    // Arbitration is only ever evaluated at a frame end, so ownership never splits a frame.
    always_comb begin
        state_d     = state;
        gnt_d       = gnt;
        word_d      = word;
        frame_cnt_d = frame_cnt;
        rr_d        = rr;
        grant_en    = 1'b0;
        grant_sel   = 1'b0;
        frame_inc   = frame_cnt + 1'b1;
        own         = (state == SHOW1);
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (req[0] && (!req[1] || !rr)) begin
                        grant_en  = 1'b1;
                        grant_sel = 1'b0;
                    end else if (req[1]) begin
                        grant_en  = 1'b1;
                        grant_sel = 1'b1;
                    end
                end
                default: begin
                    frame_cnt_d = frame_inc;
                    if (frame_inc == FW'(HOLD_FRAMES) || !req[own]) begin
                        if (req[~own]) begin
                            grant_en  = 1'b1;
                            grant_sel = ~own;
                        end else if (req[own]) begin
                            grant_en  = 1'b1;
                            grant_sel = own;
                        end else begin
                            state_d = IDLE;
                            gnt_d   = '0;
                        end
                    end
                end
            endcase
        end
        if (grant_en) begin
            state_d     = grant_sel ? SHOW1 : SHOW0;
            gnt_d       = grant_sel ? 2'b10 : 2'b01;
            word_d      = grant_sel ? val1 : val0;
            frame_cnt_d = '0;
            rr_d        = ~grant_sel;
        end
    end

    always_comb begin
        dword = (state == IDLE) ? {8'h00, pc_addr} : word;
        case (digit_sel)
            2'd0: nib = dword[3:0];
            2'd1: nib = dword[7:4];
            2'd2: nib = dword[11:8];
            default: nib = dword[15:12];
        endcase
`ifdef LZ_BLANK_EN
        case (digit_sel)
            2'd0: lit = 1'b1;
            2'd1: lit = |dword[15:4];
            2'd2: lit = |dword[15:8];
            default: lit = |dword[15:12];
        endcase
`else
        lit = 1'b1;
`endif
        an_d  = lit ? ~(4'b0001 << digit_sel) : 4'b1111;
        seg_d = lit ? hex7(nib) : 7'b1111111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            digit_sel <= '0;
            frame_cnt <= '0;
            state     <= IDLE;
            rr        <= 1'b0;
            word      <= '0;
            gnt       <= '0;
            seg       <= '1;
            an        <= '1;
        end else begin
            cnt       <= tick ? '0 : cnt + 1'b1;
            if (tick) digit_sel <= digit_sel + 1'b1;
            frame_cnt <= frame_cnt_d;
            state     <= state_d;
            rr        <= rr_d;
            word      <= word_d;
            gnt       <= gnt_d;
            seg       <= seg_d;
            an        <= an_d;
        end
    end
endmodule

// File: tb/tb_sev_seg_arb.sv
// Directed bench for sev_seg_arb at CLK_DIV=4, HOLD_FRAMES=2; frame ends land on every 16th edge after reset release.
module tb_sev_seg_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc_addr;
    logic [1:0]  req;
    logic [15:0] val0, val1;
    logic [1:0]  gnt;
    logic [6:0]  seg;
    logic [3:0]  an;
    int          total = 0;
    int          bad = 0;
    logic [1:0]  exp_gnt;

    localparam logic [6:0] S_0 = 7'b1000000, S_2 = 7'b0100100, S_3 = 7'b0110000,
                           S_4 = 7'b0011001, S_5 = 7'b0010010, S_7 = 7'b1111000,
                           S_B = 7'b0000011, S_C = 7'b1000110, S_E = 7'b0000110,
                           S_F = 7'b0001110, S_OFF = 7'b1111111;

    sev_seg_arb #(.CLK_DIV(4), .HOLD_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .req(req), .val0(val0), .val1(val1),
        .gnt(gnt), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] ean, input logic [6:0] eseg);
        chk({tag, "_an"}, {12'h0, an}, {12'h0, ean});
        chk({tag, "_seg"}, {9'h0, seg}, {9'h0, eseg});
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; pc_addr = 8'h3C; val0 = '0; val1 = '0;
        adv(3);
        chk_disp("reset", 4'b1111, S_OFF);
        chk("reset_gnt", {14'h0, gnt}, 16'h0);
        rst = 1'b0;

        // idle PC view 003C, edge counts from reset release
        adv(1);  chk_disp("idle_d0", 4'b1110, S_C);          // edge 1
        adv(4);  chk_disp("idle_d1", 4'b1101, S_3);          // edge 5
        adv(4);  chk_disp("idle_d2", 4'b1011, S_0);          // edge 9
        adv(4);  chk_disp("idle_d3", 4'b0111, S_0);          // edge 13
        chk("idle_gnt", {14'h0, gnt}, 16'h0);

        // single grant requested mid-frame
        adv(7);  req = 2'b01; val0 = 16'hBEEF;               // edge 20
        adv(11); chk("grant_pre", {14'h0, gnt}, 16'h0);      // edge 31
        adv(1);  chk("grant_edge", {14'h0, gnt}, 16'h1);     // edge 32
        adv(1);  chk_disp("beef_d0", 4'b1110, S_F);          // edge 33
        adv(4);  chk_disp("beef_d1", 4'b1101, S_E);          // edge 37
        val0 = 16'h1234;
        adv(4);  chk_disp("beef_d2", 4'b1011, S_E);          // edge 41
        adv(4);  chk_disp("stable_d3", 4'b0111, S_B);        // edge 45
        adv(18); chk("hold_pre", {14'h0, gnt}, 16'h1);       // edge 63
        adv(1);  chk("regrant", {14'h0, gnt}, 16'h1);        // edge 64
        adv(1);  chk_disp("resample_d0", 4'b1110, S_4);      // edge 65
        adv(1);  req = 2'b00;                                // edge 66
        adv(13); chk("drop_pre", {14'h0, gnt}, 16'h1);       // edge 79
        adv(1);  chk("drop_idle", {14'h0, gnt}, 16'h0);      // edge 80
        adv(1);  chk_disp("back_pc", 4'b1110, S_C);          // edge 81

        // requester 1 releases early during its first frame
        req = 2'b10; val1 = 16'h00A5;
        adv(15); chk("g1_edge", {14'h0, gnt}, 16'h2);        // edge 96
        adv(1);  chk_disp("a5_d0", 4'b1110, S_5);            // edge 97
        adv(3);  req = 2'b00;                                // edge 100
        adv(9);                                              // edge 109
`ifdef LZ_BLANK_EN
        chk_disp("a5_d3", 4'b1111, S_OFF);
`else
        chk_disp("a5_d3", 4'b0111, S_0);
`endif
        adv(2);  chk("early_pre", {14'h0, gnt}, 16'h2);      // edge 111
        adv(1);  chk("early_idle", {14'h0, gnt}, 16'h0);     // edge 112

        // contention from reset: 01 at 16, 10 at 48, 01 at 80, 10 at 112
        rst = 1'b1; req = 2'b11; val0 = 16'h0042; val1 = 16'h0007;
        adv(2);
        rst = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            adv(1);
            if (k < 16)       exp_gnt = 2'b00;
            else if (k < 48)  exp_gnt = 2'b01;
            else if (k < 80)  exp_gnt = 2'b10;
            else if (k < 112) exp_gnt = 2'b01;
            else              exp_gnt = 2'b10;
            chk("rr_gnt", {14'h0, gnt}, {14'h0, exp_gnt});
            case (k)
                17: chk_disp("v42_d0", 4'b1110, S_2);
                21: chk_disp("v42_d1", 4'b1101, S_4);
`ifdef LZ_BLANK_EN
                25: chk_disp("v42_d2", 4'b1111, S_OFF);
                29: chk_disp("v42_d3", 4'b1111, S_OFF);
`else
                25: chk_disp("v42_d2", 4'b1011, S_0);
                29: chk_disp("v42_d3", 4'b0111, S_0);
`endif
                49: chk_disp("v7_d0", 4'b1110, S_7);
                default: ;
            endcase
        end

        // reset in the middle of SHOW1 ownership
        rst = 1'b1;
        adv(1);
        chk("rst_mid_gnt", {14'h0, gnt}, 16'h0);
        chk_disp("rst_mid", 4'b1111, S_OFF);

        // zero value: only digit 0 lit when blanking
        req = 2'b01; val0 = 16'h0000;
        adv(1);
        rst = 1'b0;
        adv(16); chk("zero_gnt", {14'h0, gnt}, 16'h1);       // edge 16
        adv(1);  chk_disp("zero_d0", 4'b1110, S_0);          // edge 17
        adv(4);                                              // edge 21
`ifdef LZ_BLANK_EN
        chk_disp("zero_d1", 4'b1111, S_OFF);
`else
        chk_disp("zero_d1", 4'b1101, S_0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
